// File: rtl/stream_dot_product_lanes.sv
// rtl/stream_dot_product_lanes.sv - three-stage lane-parallel multiply-accumulate dot-product engine
// Optional clamping accumulator and out_sat port enabled by defining MAC_SATURATE_EN.
module stream_dot_product_lanes #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int LENGTH = 10,
  parameter int ACC_W  = 24,
  parameter int SIGNED = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_a,
  input  logic [LANES*DATA_W-1:0]   in_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_W-1:0]          out_data
`ifdef MAC_SATURATE_EN
  ,
  output logic                      out_sat
`endif
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = PROD_W + $clog2(LANES);
  localparam int MAX_W  = (ACC_W > SUM_W) ? ACC_W : SUM_W;
`ifdef MAC_SATURATE_EN
  // Two guard bits so the signed comparison against the clamp bounds is exact in both modes.
  localparam int WIDE_W = MAX_W + 2;
`else
  localparam int WIDE_W = MAX_W;
`endif
  localparam int CNT_W  = 8;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LENGTH - 1);
  localparam logic SX = (SIGNED != 0);

  logic                  en;
  logic                  in_fire;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  last_tag;

  logic                  s1_valid_q, s1_last_q;
  logic [PROD_W-1:0]     prod_q [LANES];
  logic [PROD_W-1:0]     prod_d [LANES];

  logic                  s2_valid_q, s2_last_q;
  logic [SUM_W-1:0]      sum_q, sum_d;

  logic [ACC_W-1:0]      acc_q, acc_next;
  logic [WIDE_W-1:0]     sum_x, acc_x, total;
  logic                  out_valid_q;
  logic [ACC_W-1:0]      out_data_q;

`ifdef MAC_SATURATE_EN
  localparam logic [WIDE_W-1:0] UMAX = WIDE_W'({ACC_W{1'b1}});
  localparam logic [WIDE_W-1:0] SMAX = WIDE_W'({(ACC_W-1){1'b1}});
  localparam logic [WIDE_W-1:0] SMIN = ~SMAX;
  localparam logic [WIDE_W-1:0] HI   = SX ? SMAX : UMAX;
  localparam logic [WIDE_W-1:0] LO   = SX ? SMIN : '0;
  logic                  clamp;
  logic                  sat_q;
  logic                  out_sat_q;
  assign out_sat = out_sat_q;
`endif

  // A held result stalls the whole pipeline, input included.
  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign in_fire   = in_valid && en;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign last_tag  = (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d = cnt_q;
    if (in_fire) begin
      cnt_d = last_tag ? '0 : cnt_q + 1'b1;
    end
  end

  always_comb begin
    logic [PROD_W+1:0] ax, bx, full;
    for (int i = 0; i < LANES; i++) begin
      ax = SX ? (PROD_W+2)'($signed(in_a[i*DATA_W +: DATA_W])) : (PROD_W+2)'(in_a[i*DATA_W +: DATA_W]);
      bx = SX ? (PROD_W+2)'($signed(in_b[i*DATA_W +: DATA_W])) : (PROD_W+2)'(in_b[i*DATA_W +: DATA_W]);
      full = ax * bx;
      prod_d[i] = full[PROD_W-1:0];
    end
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_d = sum_d + (SX ? SUM_W'($signed(prod_q[i])) : SUM_W'(prod_q[i]));
    end
  end

  always_comb begin
    sum_x    = SX ? WIDE_W'($signed(sum_q)) : WIDE_W'(sum_q);
    acc_x    = SX ? WIDE_W'($signed(acc_q)) : WIDE_W'(acc_q);
    total    = acc_x + sum_x;
    acc_next = total[ACC_W-1:0];
`ifdef MAC_SATURATE_EN
    clamp = 1'b0;
    if ($signed(total) > $signed(HI)) begin
      acc_next = HI[ACC_W-1:0];
      clamp    = 1'b1;
    end else if ($signed(total) < $signed(LO)) begin
      acc_next = LO[ACC_W-1:0];
      clamp    = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      prod_q      <= '{default: '0};
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      sum_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef MAC_SATURATE_EN
      sat_q       <= 1'b0;
      out_sat_q   <= 1'b0;
`endif
    end else if (en) begin
      cnt_q       <= cnt_d;
      s1_valid_q  <= in_valid;
      s1_last_q   <= last_tag;
      prod_q      <= prod_d;
      s2_valid_q  <= s1_valid_q;
      s2_last_q   <= s1_last_q;
      sum_q       <= sum_d;
      out_valid_q <= s2_valid_q && s2_last_q;
      if (s2_valid_q) begin
        if (s2_last_q) begin
          out_data_q <= acc_next;
          acc_q      <= '0;
        end else begin
          acc_q      <= acc_next;
        end
`ifdef MAC_SATURATE_EN
        if (s2_last_q) begin
          out_sat_q <= sat_q || clamp;
          sat_q     <= 1'b0;
        end else begin
          sat_q     <= sat_q || clamp;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_stream_dot_product_lanes.sv
// tb/tb_stream_dot_product_lanes.sv - scoreboard bench: unsigned/signed LENGTH=3 instances plus a LENGTH=1 instance
module tb_stream_dot_product_lanes;

  localparam int LEN = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;

  logic        ir_a, ir_b, ir_c, ov_a, ov_b, ov_c;
  logic [17:0] od_a;
  logic [23:0] od_b, od_c;
`ifdef MAC_SATURATE_EN
  logic        os_a, os_b, os_c;
`endif

  always #5 clk = ~clk;

  stream_dot_product_lanes #(.DATA_W(8), .LANES(4), .LENGTH(LEN), .ACC_W(18), .SIGNED(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_a), .in_a(in_a), .in_b(in_b),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a)
`ifdef MAC_SATURATE_EN
    , .out_sat(os_a)
`endif
  );

  stream_dot_product_lanes #(.DATA_W(8), .LANES(4), .LENGTH(LEN), .ACC_W(24), .SIGNED(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_b), .in_a(in_a), .in_b(in_b),
    .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b)
`ifdef MAC_SATURATE_EN
    , .out_sat(os_b)
`endif
  );

  stream_dot_product_lanes #(.DATA_W(8), .LANES(4), .LENGTH(1), .ACC_W(24), .SIGNED(0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_c), .in_a(in_a), .in_b(in_b),
    .out_valid(ov_c), .out_ready(1'b1), .out_data(od_c)
`ifdef MAC_SATURATE_EN
    , .out_sat(os_c)
`endif
  );

  typedef struct {
    longint d;
    bit     s;
  } exp_t;

  exp_t   qa[$], qb[$], qc[$];
  int     tests = 0;
  int     fails = 0;
  longint acc_a = 0, acc_b = 0;
  bit     sat_a = 0, sat_b = 0;
  int     beat_n = 0;
  bit     held_a = 0;
  longint held_val = 0;

  task automatic check(input string name, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic longint beat_sum(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint s;
    longint x;
    longint y;
    logic [7:0] ea;
    logic [7:0] eb;
    s = 0;
    for (int k = 0; k < 4; k++) begin
      ea = a[k*8 +: 8];
      eb = b[k*8 +: 8];
      x = sgn ? longint'($signed(ea)) : longint'(ea);
      y = sgn ? longint'($signed(eb)) : longint'(eb);
      s += x * y;
    end
    return s;
  endfunction

  function automatic longint sat_add(input longint acc, input longint s, input int w, input bit sgn,
                                     output bit clamped);
    longint r;
    longint hi;
    longint lo;
    r = acc + s;
    clamped = 1'b0;
`ifdef MAC_SATURATE_EN
    hi = sgn ? (longint'(1) <<< (w - 1)) - 1 : (longint'(1) <<< w) - 1;
    lo = sgn ? -(longint'(1) <<< (w - 1)) : 0;
    if (r > hi) begin r = hi; clamped = 1'b1; end
    else if (r < lo) begin r = lo; clamped = 1'b1; end
`else
    hi = 0;
    lo = 0;
`endif
    return r;
  endfunction

  function automatic longint mask(input longint v, input int w);
    return v & ((longint'(1) <<< w) - 1);
  endfunction

  function automatic logic [31:0] pack4(input int x0, input int x1, input int x2, input int x3);
    return {x3[7:0], x2[7:0], x1[7:0], x0[7:0]};
  endfunction

  // Reference model: observe accepted beats and build expected results.
  always @(negedge clk) begin
    bit c;
    longint s;
    if (rst_n) begin
      if (in_valid && ir_a) begin
        check("in_ready_match", longint'(ir_b), longint'(ir_a));
        acc_a = sat_add(acc_a, beat_sum(in_a, in_b, 1'b0), 18, 1'b0, c);
        sat_a |= c;
        acc_b = sat_add(acc_b, beat_sum(in_a, in_b, 1'b1), 24, 1'b1, c);
        sat_b |= c;
        beat_n++;
        if (beat_n == LEN) begin
          qa.push_back('{mask(acc_a, 18), sat_a});
          qb.push_back('{mask(acc_b, 24), sat_b});
          acc_a = 0; acc_b = 0; sat_a = 0; sat_b = 0; beat_n = 0;
        end
      end
      if (in_valid && ir_c) begin
        s = sat_add(0, beat_sum(in_a, in_b, 1'b0), 24, 1'b0, c);
        qc.push_back('{mask(s, 24), c});
      end
    end
  end

  // Output monitors: pop and compare on every output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ov_a && out_ready) begin
      if (qa.size() == 0) check("a_unexpected", 1, 0);
      else begin
        e = qa.pop_front();
        check("a_data", longint'(od_a), e.d);
`ifdef MAC_SATURATE_EN
        check("a_sat", longint'(os_a), longint'(e.s));
`endif
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ov_b && out_ready) begin
      if (qb.size() == 0) check("b_unexpected", 1, 0);
      else begin
        e = qb.pop_front();
        check("b_data", longint'(od_b), e.d);
`ifdef MAC_SATURATE_EN
        check("b_sat", longint'(os_b), longint'(e.s));
`endif
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ov_c) begin
      if (qc.size() == 0) check("c_unexpected", 1, 0);
      else begin
        e = qc.pop_front();
        check("c_data", longint'(od_c), e.d);
`ifdef MAC_SATURATE_EN
        check("c_sat", longint'(os_c), longint'(e.s));
`endif
      end
    end
  end

  // A stalled result must stay put and must block input.
  always @(negedge clk) begin
    if (!rst_n) held_a = 0;
    else begin
      if (held_a) begin
        check("hold_valid", longint'(ov_a), 1);
        check("hold_data", longint'(od_a), held_val);
      end
      if (ov_a && !out_ready) begin
        check("stall_in_ready", longint'(ir_a), 0);
        held_a = 1;
        held_val = longint'(od_a);
      end else held_a = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] b);
    int n;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    n = 0;
    while (!ir_a && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("beat_timeout", 1, 0);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic flush_model();
    qa.delete(); qb.delete(); qc.delete();
    acc_a = 0; acc_b = 0; sat_a = 0; sat_b = 0; beat_n = 0;
  endtask

  initial begin
    logic [31:0] va, vb;
    int n;
    va = pack4(1, 2, 3, 4);
    vb = pack4(5, 6, 7, 8);
    repeat (3) tick();
    check("rst_out_valid", longint'(ov_a), 0);
    check("rst_out_data", longint'(od_a), 0);
    check("rst_in_ready", longint'(ir_a), 1);
    rst_n = 1'b1;
    tick();

    // Basic vector and 3-cycle latency
    repeat (LEN) beat(va, vb);
    check("lat0", longint'(ov_a), 0);
    tick();
    check("lat1", longint'(ov_a), 0);
    tick();
    check("lat2", longint'(ov_a), 1);
    check("basic_210", longint'(od_a), 210);
    tick();

    // Signed: -1 * 2 across 12 elements
    repeat (LEN) beat(pack4(255, 255, 255, 255), pack4(2, 2, 2, 2));
    repeat (2) tick();
    check("signed_neg24", longint'(od_b), longint'(24'hFFFFE8));
    tick();

    // Overflow then a small vector to confirm the clamp flag clears
    repeat (LEN) beat(pack4(255, 255, 255, 255), pack4(255, 255, 255, 255));
    repeat (2) tick();
`ifdef MAC_SATURATE_EN
    check("ovf_sat_data", longint'(od_a), 262143);
    check("ovf_sat_flag", longint'(os_a), 1);
`else
    check("ovf_wrap_data", longint'(od_a), 256012);
`endif
    repeat (LEN) beat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1));
    repeat (2) tick();
    check("after_ovf_data", longint'(od_a), 12);
`ifdef MAC_SATURATE_EN
    check("after_ovf_flag", longint'(os_a), 0);
`endif
    tick();

    // Input gap inside a vector
    beat(va, vb);
    repeat (5) tick();
    beat(va, vb);
    beat(va, vb);
    repeat (2) tick();
    check("gap_210", longint'(od_a), 210);
    tick();

    // Reset mid-vector discards the partial sum
    beat(pack4(9, 9, 9, 9), pack4(9, 9, 9, 9));
    beat(pack4(9, 9, 9, 9), pack4(9, 9, 9, 9));
    rst_n = 1'b0;
    flush_model();
    #1;
    check("midrst_valid", longint'(ov_a), 0);
    check("midrst_data", longint'(od_a), 0);
    check("midrst_data_b", longint'(od_b), 0);
    tick();
    rst_n = 1'b1;
    tick();
    repeat (LEN) beat(va, vb);
    repeat (2) tick();
    check("post_rst_210", longint'(od_a), 210);
    tick();

    // Backpressure across two vectors
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 2 * LEN; i++) beat($urandom, $urandom);
      end
      begin
        repeat (20) tick();
        out_ready = 1'b1;
      end
    join
    repeat (6) tick();

    // LENGTH=1 instance: a result every cycle once filled
    in_valid = 1'b1;
    in_a = pack4(1, 1, 1, 1);
    in_b = pack4(1, 1, 1, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i >= 3) begin
        check("len1_valid", longint'(ov_c), 1);
        check("len1_data", longint'(od_c), 4);
      end
    end
    in_valid = 1'b0;

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom % 10) < 7;
      in_a = $urandom;
      in_b = $urandom;
      out_ready = ($urandom % 10) < 6;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((qa.size() + qb.size() + qc.size()) != 0 && n < 50) begin
      tick();
      n++;
    end
    check("drain_empty", longint'(qa.size() + qb.size() + qc.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
